muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Sequencer between the multicycle control unit and the iterative mult/div datapath core.
- Accepts a one-cycle start command and prepares operands: absolute values for signed divide.
- Drives the core, waits for its Done flag, then sign-corrects the result.
- Owns the architectural HI/LO registers (mfhi/mflo read, mthi/mtlo write). Raises busy for stall and div-by-zero / timeout exceptions.

Parameters:
MAX_CYCLES, 40, RUN-state cycle limit before abort with timeout error.

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
start  in  1  one-cycle command pulse, sampled only in IDLE
op  in  2  00 mult (signed), 01 div (signed), 10 divu, 11 reserved (ignored)
opa  in  32  rs operand (multiplicand / dividend)
opb  in  32  rt operand (multiplier / divisor)
hi_we  in  1  mthi write enable
lo_we  in  1  mtlo write enable
wr_data  in  32  mthi/mtlo data
core_sel  out  1  core HDControl: 0 mult, 1 div
core_a  out  32  core operand A
core_b  out  32  core operand B
core_rst  out  1  core synchronous clear
core_hi  in  32  core HI result
core_lo  in  32  core LO result
core_done  in  1  core Done
HI  out  32  architectural HI register
LO  out  32  architectural LO register
busy  out  1  stall request to control unit
done  out  1  one-cycle completion pulse
div_by0  out  1  one-cycle divide-by-zero exception pulse
timeout  out  1  one-cycle core-hang error pulse

Behaviour:
- Reset (async): state IDLE; HI=LO=0; busy=done=div_by0=timeout=0; core_rst=1; core_sel=0; core_a=core_b=0; cycle counter=0.
- States: IDLE, CLR, RUN, FIX.
- IDLE:
  - core_rst=1, busy=0.
  - start with op=11: ignored.
  - start with op div/divu and opb==0: HI/LO unchanged; done=1 and div_by0=1 on the next edge; stay IDLE.
  - Otherwise on start, latch into internal regs:
    - op.
    - neg_q = signed div and opa[31]^opb[31].
    - neg_r = signed div and opa[31].
    - core_a/core_b: for signed div, two's-complement absolute values (|0x80000000| = 0x80000000 unsigned); otherwise raw operands.
  - Set core_sel=(op!=00), busy=1, go to CLR.
- CLR: one cycle; core_rst=1; counter cleared; next state RUN.
- RUN:
  - core_rst=0; operands and core_sel held stable; counter increments each cycle.
  - core_done=1 → FIX.
  - counter reaches MAX_CYCLES-1 without core_done → abort: timeout=1 pulse, HI/LO unchanged, go IDLE.
- FIX: one cycle.
  - mult: HI=core_hi, LO=core_lo.
  - div/divu: LO=neg_q ? -core_lo : core_lo; HI=neg_r ? -core_hi : core_hi.
  - Then done=1 pulse, busy=0, go IDLE. HI/LO new values and done are visible in the same cycle.
- Latency: done asserts (core cycles + 3) edges after the start edge.
- busy is high from the edge after start until the edge where done rises, inclusive of FIX.
- mthi/mtlo:
  - Honoured only in IDLE.
  - If they coincide with a start, the write takes effect and the op then overwrites HI/LO.
  - Ignored while busy.
  - hi_we and lo_we may both be high: both registers take wr_data.
- start while busy: ignored, no queueing.
- Overflow case −2^31 / −1 (signed): LO=0x80000000, HI=0, no exception.
- Reset asserted mid-operation: immediate IDLE with all reset values; no done pulse; HI/LO cleared.
- done, div_by0 and timeout are registered, never combinational from inputs.

Test Plan:
- Signed mult: start, op=00, opa=0xFFFFFFFD (−3), opb=7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB; done one cycle; busy high throughout.
- Signed div: op=01, opa=−7 (0xFFFFFFF9), opb=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); also opa=7, opb=−2 → LO=−3, HI=1.
- divu: op=10, opa=0xFFFFFFF9, opb=2 → LO=0x7FFFFFFC, HI=1; then divide by zero with opb=0 → div_by0 and done pulse next edge, HI/LO unchanged, busy never asserted.
- Core hang: hold core_done=0 with MAX_CYCLES=40 → timeout pulse after 40 RUN cycles, HI/LO unchanged, back to IDLE.
- mthi/mtlo: hi_we=1, wr_data=0x12345678 in IDLE → HI updates; repeat while busy → ignored; second start during busy → ignored.
- Async reset asserted in RUN → outputs at reset values before the next clock edge; a following mult 5×6 completes with LO=30, HI=0.

Source files
------------

// File: rtl/muldiv_seq.sv
// Sequencer between the control unit and the iterative mult/div core: prepares operands,
// runs the core, sign-corrects results and owns the architectural HI/LO registers.
module muldiv_seq #(
  parameter int unsigned MAX_CYCLES = 40
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] wr_data,
  output logic        core_sel,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic        core_rst,
  input  logic [31:0] core_hi,
  input  logic [31:0] core_lo,
  input  logic        core_done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        done,
  output logic        div_by0,
  output logic        timeout
);

  localparam int unsigned CntW = (MAX_CYCLES > 2) ? $clog2(MAX_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StClr, StRun, StFix} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic [CntW-1:0] cnt_q;

  logic        is_div;
  logic        is_sdiv;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    is_div  = (op == 2'b01) || (op == 2'b10);
    is_sdiv = (op == 2'b01);
    // |0x80000000| wraps to itself, which is the correct unsigned magnitude.
    abs_a   = opa[31] ? (32'd0 - opa) : opa;
    abs_b   = opb[31] ? (32'd0 - opb) : opb;
    fix_hi  = neg_rem_q ? (32'd0 - core_hi) : core_hi;
    fix_lo  = neg_quo_q ? (32'd0 - core_lo) : core_lo;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      op_q      <= 2'b00;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      cnt_q     <= '0;
      core_sel  <= 1'b0;
      core_a    <= 32'd0;
      core_b    <= 32'd0;
      core_rst  <= 1'b1;
      HI        <= 32'd0;
      LO        <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_by0   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      done    <= 1'b0;
      div_by0 <= 1'b0;
      timeout <= 1'b0;
      unique case (state_q)
        StIdle: begin
          core_rst <= 1'b1;
          busy     <= 1'b0;
          if (hi_we) HI <= wr_data;
          if (lo_we) LO <= wr_data;
          if (start && (op != 2'b11)) begin
            if (is_div && (opb == 32'd0)) begin
              done    <= 1'b1;
              div_by0 <= 1'b1;
            end else begin
              op_q      <= op;
              neg_quo_q <= is_sdiv && (opa[31] ^ opb[31]);
              neg_rem_q <= is_sdiv && opa[31];
              core_a    <= is_sdiv ? abs_a : opa;
              core_b    <= is_sdiv ? abs_b : opb;
              core_sel  <= (op != 2'b00);
              busy      <= 1'b1;
              state_q   <= StClr;
            end
          end
        end
        StClr: begin
          // core_rst was high during this cycle; release it for RUN.
          core_rst <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StRun;
        end
        StRun: begin
          if (core_done) begin
            state_q <= StFix;
          end else if (cnt_q == CntW'(MAX_CYCLES - 1)) begin
            timeout  <= 1'b1;
            busy     <= 1'b0;
            core_rst <= 1'b1;
            state_q  <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFix: begin
          if (op_q == 2'b00) begin
            HI <= core_hi;
            LO <= core_lo;
          end else begin
            HI <= fix_hi;
            LO <= fix_lo;
          end
          done     <= 1'b1;
          busy     <= 1'b0;
          core_rst <= 1'b1;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: a behavioural core stub plus table-driven vectors and
// hand sequences for div-by-zero, HI/LO writes, timeout and async reset.
module tb_muldiv_seq;

  localparam int CoreLat = 5;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_data;
  logic        core_sel;
  logic [31:0] core_a;
  logic [31:0] core_b;
  logic        core_rst;
  logic [31:0] core_hi = 32'd0;
  logic [31:0] core_lo = 32'd0;
  logic        core_done = 1'b0;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        div_by0;
  logic        timeout;

  muldiv_seq #(.MAX_CYCLES(40)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .hi_we(hi_we), .lo_we(lo_we), .wr_data(wr_data), .core_sel(core_sel),
    .core_a(core_a), .core_b(core_b), .core_rst(core_rst), .core_hi(core_hi),
    .core_lo(core_lo), .core_done(core_done), .HI(HI), .LO(LO), .busy(busy),
    .done(done), .div_by0(div_by0), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Core stub: fixed latency after core_rst drops; hang suppresses done.
  logic        hang = 1'b0;
  int          ccnt = 0;
  logic signed [63:0] prod;
  assign prod = $signed(core_a) * $signed(core_b);

  always @(posedge clock) begin
    if (core_rst) begin
      ccnt      <= 0;
      core_done <= 1'b0;
    end else if (!hang) begin
      ccnt <= ccnt + 1;
      if (ccnt == CoreLat - 1) begin
        core_done <= 1'b1;
        if (!core_sel) begin
          core_hi <= prod[63:32];
          core_lo <= prod[31:0];
        end else begin
          core_hi <= core_a % core_b;
          core_lo <= core_a / core_b;
        end
      end
    end
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Issue a start and count edges until done, noting any cycle where busy was low.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_low);
    @(negedge clock);
    op = o; opa = a; opb = b; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0;
    busy_low = 0;
    while (!done && lat < 100) begin
      if (!busy) busy_low++;
      @(posedge clock);
      #1 lat++;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[8];

  int lat;
  int busy_low;
  int n;
  int seen;

  initial begin
    vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1] = '{2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[2] = '{2'b01, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[3] = '{2'b10, 32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC};
    vecs[4] = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5] = '{2'b00, 32'd5,        32'd6,        32'h00000000, 32'd30};
    vecs[6] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[7] = '{2'b01, 32'hFFFFFFF7, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h00000002};

    reset = 1'b1; start = 1'b0; op = 2'b00; opa = 0; opb = 0;
    hi_we = 1'b0; lo_we = 1'b0; wr_data = 0;
    #23;
    check("reset HI", HI, 32'd0);
    check("reset LO", LO, 32'd0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset core_rst", {31'd0, core_rst}, 32'd1);
    check("reset core_sel", {31'd0, core_sel}, 32'd0);
    check("reset core_a", core_a, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy_low);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(CoreLat + 3));
      check($sformatf("vec%0d busy gaps", i), 32'(busy_low), 32'd0);
      check($sformatf("vec%0d busy at done", i), {31'd0, busy}, 32'd0);
      check($sformatf("vec%0d HI", i), HI, vecs[i].hi);
      check($sformatf("vec%0d LO", i), LO, vecs[i].lo);
      @(posedge clock);
      #1 check($sformatf("vec%0d done width", i), {31'd0, done}, 32'd0);
    end

    // mthi + mtlo together in IDLE.
    @(negedge clock);
    hi_we = 1'b1; lo_we = 1'b1; wr_data = 32'h12345678;
    @(negedge clock);
    hi_we = 1'b0; lo_we = 1'b0;
    check("mthi HI", HI, 32'h12345678);
    check("mtlo LO", LO, 32'h12345678);

    // Divide by zero: immediate done + div_by0, no busy, HI/LO untouched.
    run_op(2'b01, 32'd9, 32'd0, lat, busy_low);
    check("div0 latency", 32'(lat), 32'd0);
    check("div0 flag", {31'd0, div_by0}, 32'd1);
    check("div0 busy", {31'd0, busy}, 32'd0);
    check("div0 HI", HI, 32'h12345678);
    check("div0 LO", LO, 32'h12345678);
    @(posedge clock);
    #1 check("div0 pulse width", {30'd0, done, div_by0}, 32'd0);

    // Reserved op is ignored.
    @(negedge clock);
    op = 2'b11; opa = 32'd3; opb = 32'd4; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("op11 busy", {31'd0, busy}, 32'd0);
    check("op11 done", {31'd0, done}, 32'd0);

    // mtlo coinciding with a signed div start: write lands, then result overwrites.
    @(negedge clock);
    op = 2'b01; opa = 32'd7; opb = 32'hFFFFFFFE; start = 1'b1;
    lo_we = 1'b1; wr_data = 32'hAAAA5555;
    @(posedge clock);
    #1 start = 1'b0; lo_we = 1'b0;
    check("coincident mtlo LO", LO, 32'hAAAA5555);
    check("div core_sel", {31'd0, core_sel}, 32'd1);
    check("div core_b abs", core_b, 32'd2);
    // Writes and a second start while busy must be ignored.
    @(negedge clock);
    hi_we = 1'b1; wr_data = 32'hDEADBEEF; start = 1'b1; op = 2'b00; opa = 32'd9;
    @(negedge clock);
    hi_we = 1'b0; start = 1'b0;
    check("busy mthi ignored", HI, 32'h12345678);
    check("busy start ignored core_a", core_a, 32'd7);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clock);
      #1 n++;
    end
    check("busy seq done seen", {31'd0, done}, 32'd1);
    check("busy seq LO", LO, 32'hFFFFFFFD);
    check("busy seq HI", HI, 32'h00000001);
    @(posedge clock);
    #1 check("no queued op", {31'd0, busy}, 32'd0);

    // Core hang: timeout after 40 RUN cycles, HI/LO unchanged.
    hang = 1'b1;
    @(negedge clock);
    op = 2'b00; opa = 32'd2; opb = 32'd3; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    n = 0;
    seen = 0;
    while (!timeout && n < 200) begin
      if (done) seen++;
      @(posedge clock);
      #1 n++;
    end
    check("timeout edge", 32'(n), 32'd41);
    check("timeout busy", {31'd0, busy}, 32'd0);
    check("timeout no done", 32'(seen) + {31'd0, done}, 32'd0);
    check("timeout HI", HI, 32'h00000001);
    check("timeout LO", LO, 32'hFFFFFFFD);
    @(posedge clock);
    #1 check("timeout pulse width", {31'd0, timeout}, 32'd0);
    hang = 1'b0;

    // Async reset in RUN.
    @(negedge clock);
    op = 2'b00; opa = 32'd11; opb = 32'd13; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst HI", HI, 32'd0);
    check("async rst LO", LO, 32'd0);
    check("async rst core_rst", {31'd0, core_rst}, 32'd1);
    check("async rst core_a", core_a, 32'd0);
    #3 reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clock);
      #1 if (done) seen++;
    end
    check("no done after reset", 32'(seen), 32'd0);
    run_op(2'b00, 32'd5, 32'd6, lat, busy_low);
    check("post-reset latency", 32'(lat), 32'(CoreLat + 3));
    check("post-reset LO", LO, 32'd30);
    check("post-reset HI", HI, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
